// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared sizing helpers, code position map and FSM states for the SECDED decoder
package hamming_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    DECODE,
    OUTPUT
  } state_t;

  function automatic int code_n(input int m);
    return 1 << m;
  endfunction

  function automatic int data_k(input int m);
    return (1 << m) - m - 1;
  endfunction

  function automatic bit is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Data bit idx lives at the idx-th non-power-of-2 position, counting up from position 3.
  function automatic int data_pos(input int m, input int idx);
    int seen;
    int pos;
    seen = 0;
    pos  = 0;
    for (int p = 3; p < (1 << m); p++) begin
      if (!is_pow2(p)) begin
        if (seen == idx) pos = p;
        seen++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// rtl/hamming_syndrome.sv - combinational syndrome, overall parity and single-bit correction
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int M = 3
) (
  input  logic [code_n(M)-1:0] code,
  output logic [M-1:0]         syndrome,
  output logic                 parity,
  output logic [code_n(M)-1:0] corrected_code
);

  localparam int N = code_n(M);

  always_comb begin
    syndrome = '0;
    for (int p = 1; p < N; p++) begin
      if (code[p]) syndrome = syndrome ^ M'(p);
    end
    parity = ^code;
    // Odd overall parity means one flipped bit at the syndrome position; s=0 points at the parity bit.
    corrected_code = code;
    if (parity) corrected_code[syndrome] = ~code[syndrome];
  end

endmodule

// File: rtl/hamming_secded_rx.sv
// rtl/hamming_secded_rx.sv - serial-in SECDED decoder with handshaked output and error statistics
module hamming_secded_rx
  import hamming_pkg::*;
#(
  parameter int M         = 3,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_bit,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [data_k(M)-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_corrected,
  output logic                 out_uncorrectable,
  output logic [M-1:0]         out_syndrome,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     cnt_corrected,
  output logic [CNT_W-1:0]     cnt_uncorrectable
);

  localparam int N = code_n(M);
  localparam int K = data_k(M);

  state_t         state;
  state_t         state_nxt;
  logic [M-1:0]   bit_cnt;
  logic [M-1:0]   wr_pos;
  logic [N-1:0]   code_q;
  logic [N-1:0]   fixed_code;
  logic [M-1:0]   syn;
  logic           par;
  logic [K-1:0]   data_raw;
  logic [K-1:0]   data_fixed;
  logic           accept;
  logic           handshake;
  logic           is_corr;
  logic           is_unc;
  logic           unused_check_bits;

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == OUTPUT);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  // N is a power of two, so N-1-cnt is just the bitwise inverse of the counter.
  assign wr_pos = LSB_FIRST ? bit_cnt : ~bit_cnt;

  hamming_syndrome #(
    .M (M)
  ) u_syndrome (
    .code           (code_q),
    .syndrome       (syn),
    .parity         (par),
    .corrected_code (fixed_code)
  );

  assign is_corr = par;
  assign is_unc  = !par && (syn != '0);

  for (genvar i = 0; i < K; i++) begin : g_data
    localparam int POS = data_pos(M, i);
    assign data_raw[i]   = code_q[POS];
    assign data_fixed[i] = fixed_code[POS];
  end

  // Check-bit positions of the corrected word are not presented downstream.
  assign unused_check_bits = ^fixed_code;

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (accept && (&bit_cnt)) state_nxt = DECODE;
      DECODE:  state_nxt = OUTPUT;
      OUTPUT:  if (handshake) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= COLLECT;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      code_q  <= '0;
    end else if (accept) begin
      code_q[wr_pos] <= in_bit;
      bit_cnt        <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data          <= '0;
      out_syndrome      <= '0;
      out_corrected     <= 1'b0;
      out_uncorrectable <= 1'b0;
    end else if (state == DECODE) begin
      out_data          <= is_unc ? data_raw : data_fixed;
      out_syndrome      <= syn;
      out_corrected     <= is_corr;
      out_uncorrectable <= is_unc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_stats) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else if (state == DECODE) begin
      if (is_corr && (cnt_corrected != '1))     cnt_corrected     <= cnt_corrected + 1'b1;
      if (is_unc && (cnt_uncorrectable != '1)) cnt_uncorrectable <= cnt_uncorrectable + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_secded_rx.sv
// tb/tb_hamming_secded_rx.sv - scoreboard bench for hamming_secded_rx (M=3, LSB first, 2-bit counters)
module tb_hamming_secded_rx;

  logic       clk;
  logic       reset;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_corrected;
  logic       out_uncorrectable;
  logic [2:0] out_syndrome;
  logic       clr_stats;
  logic [1:0] cnt_corrected;
  logic [1:0] cnt_uncorrectable;

  typedef struct {
    logic [3:0] data;
    logic [2:0] syn;
    logic       corr;
    logic       unc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_cc     = 0;
  int   m_cu     = 0;

  hamming_secded_rx #(
    .M         (3),
    .LSB_FIRST (1'b1),
    .CNT_W     (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_bit            (in_bit),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_corrected     (out_corrected),
    .out_uncorrectable (out_uncorrectable),
    .out_syndrome      (out_syndrome),
    .clr_stats         (clr_stats),
    .cnt_corrected     (cnt_corrected),
    .cnt_uncorrectable (cnt_uncorrectable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic [2:0] s, input logic c, input logic u);
    exp_t e;
    e.data = d;
    e.syn  = s;
    e.corr = c;
    e.unc  = u;
    sb.push_back(e);
  endtask

  task automatic send_bits(input logic [7:0] code, input int nbits, input bit gaps);
    int  idx;
    int  guard;
    logic acc;
    idx   = 0;
    guard = 0;
    while (idx < nbits && guard < 500) begin
      in_bit   = code[idx];
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    if (idx < nbits) check("send_timeout", 32'(idx), 32'(nbits));
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_syndrome"}, 32'(out_syndrome), 32'd0);
    check({tag, "_out_corrected"}, 32'(out_corrected), 32'd0);
    check({tag, "_out_uncorrectable"}, 32'(out_uncorrectable), 32'd0);
    check({tag, "_cnt_corrected"}, 32'(cnt_corrected), 32'd0);
    check({tag, "_cnt_uncorrectable"}, 32'(cnt_uncorrectable), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      m_cc = 0;
      m_cu = 0;
    end else if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_syndrome", 32'(out_syndrome), 32'(e.syn));
        check("out_corrected", 32'(out_corrected), 32'(e.corr));
        check("out_uncorrectable", 32'(out_uncorrectable), 32'(e.unc));
        if (clr_stats) begin
          m_cc = 0;
          m_cu = 0;
        end else begin
          if (e.corr && m_cc < 3) m_cc++;
          if (e.unc && m_cu < 3) m_cu++;
        end
        check("cnt_corrected", 32'(cnt_corrected), 32'(m_cc));
        check("cnt_uncorrectable", 32'(cnt_uncorrectable), 32'(m_cu));
      end
    end
  end

  initial begin
    int guard;
    reset     = 1'b1;
    in_bit    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_stats = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;

    push(4'b1011, 3'd0, 1'b0, 1'b0);
    send_bits(8'hAA, 8, 1'b0);
    push(4'b1011, 3'd5, 1'b1, 1'b0);
    send_bits(8'h8A, 8, 1'b0);
    push(4'b1011, 3'd0, 1'b1, 1'b0);
    send_bits(8'hAB, 8, 1'b0);
    push(4'b1111, 3'd4, 1'b0, 1'b1);
    send_bits(8'hEE, 8, 1'b0);
    wait_drain();

    // Output stall with random input gaps and in_valid pressure during the stall.
    out_ready = 1'b0;
    push(4'b1011, 3'd5, 1'b1, 1'b0);
    send_bits(8'h8A, 8, 1'b1);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("stall_out_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_data", 32'(out_data), 32'(sb[0].data));
      check("stall_out_syndrome", 32'(out_syndrome), 32'(sb[0].syn));
      check("stall_out_corrected", 32'(out_corrected), 32'(sb[0].corr));
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    push(4'b1011, 3'd0, 1'b0, 1'b0);
    send_bits(8'hAA, 8, 1'b1);

    // Corrected counter is already at 3 here, so this must saturate.
    push(4'b1011, 3'd0, 1'b1, 1'b0);
    send_bits(8'hAB, 8, 1'b0);
    wait_drain();

    clr_stats = 1'b1;
    push(4'b1111, 3'd4, 1'b0, 1'b1);
    send_bits(8'hEE, 8, 1'b0);
    wait_drain();
    clr_stats = 1'b0;
    push(4'b1011, 3'd5, 1'b1, 1'b0);
    send_bits(8'h8A, 8, 1'b0);
    wait_drain();

    // Reset with half a word collected; the partial word must be discarded.
    send_bits(8'hAA, 4, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midword_reset");
    @(posedge clk);
    #1;
    push(4'b1011, 3'd0, 1'b0, 1'b0);
    send_bits(8'hAA, 8, 1'b0);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
